// File: rtl/mem_defs.sv
// Shared access-mode codes for the arbitrated word memory.
package mem_defs;

  localparam int MODE_W = 2;

  typedef enum logic [MODE_W-1:0] {
    MMODE_READ  = 2'd0,
    MMODE_WRITE = 2'd1,
    MMODE_SWAP  = 2'd2,
    MMODE_RSVD  = 2'd3
  } mmode_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first eligible port after the last-granted one.
module rr_arbiter #(
  parameter int N  = 3,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  eligible,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx
);

  logic [IW-1:0] last_q;

  // Scan from farthest to nearest so the nearest eligible port wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    for (int k = N; k >= 1; k--) begin
      if (eligible[(int'(last_q) + k) % N]) begin
        grant                              = '0;
        grant[(int'(last_q) + k) % N]      = 1'b1;
        grant_idx                          = IW'((int'(last_q) + k) % N);
      end
    end
  end

  // Pointer starts at the last port so port 0 has top priority out of reset.
  always_ff @(posedge clk) begin
    if (!rst_n)         last_q <= IW'(N - 1);
    else if (|eligible) last_q <= grant_idx;
  end

endmodule

// File: rtl/arbitrated_memory.sv
// Multi-port word memory: round-robin arbitration, read/write/swap, out-of-range error response.
module arbitrated_memory
  import mem_defs::*;
#(
  parameter int NUM_PORTS = 3,
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 16,
  parameter int DEPTH     = 65536
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_PORTS-1:0]          request,
  input  logic [MODE_W*NUM_PORTS-1:0]   mode,
  input  logic [ADDR_W*NUM_PORTS-1:0]   locator,
  input  logic [DATA_W*NUM_PORTS-1:0]   write_bus,
  output logic [DATA_W*NUM_PORTS-1:0]   read_bus,
  output logic [NUM_PORTS-1:0]          response,
  output logic [NUM_PORTS-1:0]          error
);

  localparam int IW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int MW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [NUM_PORTS-1:0][MODE_W-1:0] mode_a;
  logic [NUM_PORTS-1:0][ADDR_W-1:0] loc_a;
  logic [NUM_PORTS-1:0][DATA_W-1:0] wdata_a;
  logic [NUM_PORTS-1:0][DATA_W-1:0] rdata_q, rdata_d;
  logic [NUM_PORTS-1:0]             armed_q, armed_d;
  logic [NUM_PORTS-1:0]             resp_q, resp_d;
  logic [NUM_PORTS-1:0]             err_q, err_d;
  logic [NUM_PORTS-1:0]             eligible, grant;
  logic [IW-1:0]                    gidx;

  mmode_e            sel_mode;
  logic [ADDR_W-1:0] sel_loc;
  logic [DATA_W-1:0] sel_wdata;
  logic              gnt_any, in_range, bad, mem_we;
  logic [MW-1:0]     mem_idx;
  logic [DATA_W-1:0] mem_rd;
  logic [DATA_W-1:0] mem [DEPTH];

  assign mode_a  = mode;
  assign loc_a   = locator;
  assign wdata_a = write_bus;

  assign eligible = request & armed_q;

  rr_arbiter #(.N(NUM_PORTS), .IW(IW)) u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .eligible  (eligible),
    .grant     (grant),
    .grant_idx (gidx)
  );

  assign gnt_any   = |grant;
  assign sel_mode  = mmode_e'(mode_a[gidx]);
  assign sel_loc   = loc_a[gidx];
  assign sel_wdata = wdata_a[gidx];
  assign in_range  = ({1'b0, sel_loc} < (ADDR_W+1)'(DEPTH));
  assign bad       = (sel_mode == MMODE_RSVD) || !in_range;
  assign mem_idx   = sel_loc[MW-1:0];
  assign mem_rd    = mem[mem_idx];
  assign mem_we    = gnt_any && !bad &&
                     (sel_mode == MMODE_WRITE || sel_mode == MMODE_SWAP);

  // A port re-arms only after it has been seen low, so a held request gets one access.
  always_comb begin
    armed_d = (armed_q | ~request) & ~grant;
    resp_d  = grant;
    err_d   = '0;
    rdata_d = rdata_q;
    if (gnt_any) begin
      err_d[gidx] = bad;
      if (bad)                           rdata_d[gidx] = '0;
      else if (sel_mode != MMODE_WRITE)  rdata_d[gidx] = mem_rd;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      armed_q <= '0;
      resp_q  <= '0;
      err_q   <= '0;
      rdata_q <= '0;
    end else begin
      armed_q <= armed_d;
      resp_q  <= resp_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  // Contents are not reset, but an access granted while reset is asserted is dropped.
  always_ff @(posedge clk) begin
    if (rst_n && mem_we) mem[mem_idx] <= sel_wdata;
  end

  assign read_bus = rdata_q;
  assign response = resp_q;
  assign error    = err_q;

endmodule

// File: tb/tb_arbitrated_memory.sv
// Bench for arbitrated_memory: directed table, multi-cycle corner sequences, random vs. reference model.
module tb_arbitrated_memory;

  localparam int NP = 3;
  localparam int DW = 16;
  localparam int AW = 16;
  localparam int DEPTH = 1024;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NP-1:0]     request;
  logic [2*NP-1:0]   mode;
  logic [AW*NP-1:0]  locator;
  logic [DW*NP-1:0]  write_bus;
  logic [DW*NP-1:0]  read_bus;
  logic [NP-1:0]     response;
  logic [NP-1:0]     error;

  logic [1:0]  md [NP];
  logic [15:0] lc [NP];
  logic [15:0] wd [NP];

  int total = 0;
  int bad = 0;

  arbitrated_memory #(.NUM_PORTS(NP), .DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .request(request), .mode(mode), .locator(locator),
    .write_bus(write_bus), .read_bus(read_bus), .response(response), .error(error)
  );

  always #5 clk = ~clk;

  always_comb begin
    mode = '0;
    locator = '0;
    write_bus = '0;
    for (int i = 0; i < NP; i++) begin
      mode[2*i +: 2]       = md[i];
      locator[AW*i +: AW]  = lc[i];
      write_bus[DW*i +: DW] = wd[i];
    end
  end

  // Reference model: spec rules over plain arrays.
  int          m_last;
  bit          m_armed [NP];
  logic [15:0] m_mem [DEPTH];
  bit          m_known [DEPTH];
  logic [15:0] e_rd [NP];
  bit          e_rdv [NP];
  logic [NP-1:0] e_resp, e_err;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    int g;
    g = -1;
    e_resp = '0;
    e_err  = '0;
    if (!rst_n) begin
      m_last = NP - 1;
      for (int i = 0; i < NP; i++) begin
        m_armed[i] = 0; e_rd[i] = '0; e_rdv[i] = 1;
      end
    end else begin
      for (int k = 1; k <= NP; k++) begin
        int p;
        p = (m_last + k) % NP;
        if (g < 0 && request[p] && m_armed[p]) g = p;
      end
      for (int i = 0; i < NP; i++) m_armed[i] = m_armed[i] | !request[i];
      if (g >= 0) begin
        m_armed[g] = 0;
        m_last = g;
        e_resp[g] = 1'b1;
        if (md[g] == 2'd3 || int'(lc[g]) >= DEPTH) begin
          e_err[g] = 1'b1; e_rd[g] = '0; e_rdv[g] = 1;
        end else if (md[g] == 2'd1) begin
          m_mem[lc[g]] = wd[g]; m_known[lc[g]] = 1;
        end else begin
          e_rd[g] = m_mem[lc[g]]; e_rdv[g] = m_known[lc[g]];
          if (md[g] == 2'd2) begin
            m_mem[lc[g]] = wd[g]; m_known[lc[g]] = 1;
          end
        end
      end
    end
    @(posedge clk);
    #1;
    chk("model_response", 64'(response), 64'(e_resp));
    chk("model_error", 64'(error & e_resp), 64'(e_err));
    for (int i = 0; i < NP; i++)
      if (e_rdv[i]) chk($sformatf("model_read_bus%0d", i), 64'(read_bus[DW*i +: DW]), 64'(e_rd[i]));
  endtask

  typedef struct {
    logic        rst;
    logic [2:0]  req;
    int          port;
    logic [1:0]  md;
    logic [15:0] loc;
    logic [15:0] wd;
    logic [2:0]  er;
    logic [2:0]  ee;
    logic [15:0] erd;
  } vec_t;

  function automatic vec_t mk(logic r, logic [2:0] rq, int p, logic [1:0] m, logic [15:0] l,
                              logic [15:0] w, logic [2:0] er, logic [2:0] ee, logic [15:0] erd);
    vec_t v;
    v.rst = r; v.req = rq; v.port = p; v.md = m; v.loc = l; v.wd = w;
    v.er = er; v.ee = ee; v.erd = erd;
    return v;
  endfunction

  vec_t tbl [16];
  int   order [$];
  int   done [NP];
  bit   served [NP];
  int   cnt;
  int   r;

  initial begin
    rst_n = 1'b0;
    request = '0;
    for (int i = 0; i < NP; i++) begin md[i] = 0; lc[i] = 0; wd[i] = 0; e_rdv[i] = 0; e_rd[i] = 0; end
    for (int a = 0; a < DEPTH; a++) begin m_known[a] = 0; m_mem[a] = '0; end
    m_last = NP - 1;

    //           rst req    port md  loc    wdata    resp   err    rd
    tbl[0]  = mk(0, 3'b000, 0, 0, 16'd0,    16'h0,    3'b000, 3'b000, 16'h0);
    tbl[1]  = mk(1, 3'b000, 0, 0, 16'd0,    16'h0,    3'b000, 3'b000, 16'h0);
    tbl[2]  = mk(1, 3'b001, 0, 1, 16'd5,    16'hBEEF, 3'b001, 3'b000, 16'h0);
    tbl[3]  = mk(1, 3'b000, 0, 1, 16'd5,    16'hBEEF, 3'b000, 3'b000, 16'h0);
    tbl[4]  = mk(1, 3'b001, 0, 0, 16'd5,    16'h0,    3'b001, 3'b000, 16'hBEEF);
    tbl[5]  = mk(1, 3'b000, 0, 0, 16'd5,    16'h0,    3'b000, 3'b000, 16'hBEEF);
    tbl[6]  = mk(1, 3'b010, 1, 2, 16'd5,    16'h1234, 3'b010, 3'b000, 16'hBEEF);
    tbl[7]  = mk(1, 3'b000, 1, 2, 16'd5,    16'h1234, 3'b000, 3'b000, 16'hBEEF);
    tbl[8]  = mk(1, 3'b010, 1, 0, 16'd5,    16'h0,    3'b010, 3'b000, 16'h1234);
    tbl[9]  = mk(1, 3'b000, 1, 0, 16'd5,    16'h0,    3'b000, 3'b000, 16'h1234);
    tbl[10] = mk(1, 3'b001, 0, 0, 16'd1024, 16'h0,    3'b001, 3'b001, 16'h0);
    tbl[11] = mk(1, 3'b000, 0, 0, 16'd1024, 16'h0,    3'b000, 3'b000, 16'h0);
    tbl[12] = mk(1, 3'b100, 2, 3, 16'd5,    16'hDEAD, 3'b100, 3'b100, 16'h0);
    tbl[13] = mk(1, 3'b000, 2, 3, 16'd5,    16'hDEAD, 3'b000, 3'b000, 16'h0);
    tbl[14] = mk(1, 3'b100, 2, 0, 16'd5,    16'h0,    3'b100, 3'b000, 16'h1234);
    tbl[15] = mk(1, 3'b000, 2, 0, 16'd5,    16'h0,    3'b000, 3'b000, 16'h1234);

    for (int t = 0; t < 16; t++) begin
      rst_n = tbl[t].rst;
      request = tbl[t].req;
      md[tbl[t].port] = tbl[t].md;
      lc[tbl[t].port] = tbl[t].loc;
      wd[tbl[t].port] = tbl[t].wd;
      step();
      chk($sformatf("tbl%0d_response", t), 64'(response), 64'(tbl[t].er));
      chk($sformatf("tbl%0d_error", t), 64'(error & tbl[t].er), 64'(tbl[t].ee));
      chk($sformatf("tbl%0d_read_bus", t), 64'(read_bus[DW*tbl[t].port +: DW]), 64'(tbl[t].erd));
    end

    // All three request together, re-arming after each response.
    for (int i = 0; i < NP; i++) begin request[i] = 1; md[i] = 0; lc[i] = 16'(i); done[i] = 0; end
    for (int c = 0; c < 40 && (done[0] < 2 || done[1] < 2 || done[2] < 2); c++) begin
      step();
      chk("rr_one_response", 64'($countones(response) <= 1), 64'd1);
      for (int i = 0; i < NP; i++) begin
        if (response[i]) begin
          order.push_back(i); done[i]++; request[i] = 0;
        end else if (!request[i] && done[i] < 2) request[i] = 1;
      end
    end
    chk("rr_count", 64'(order.size()), 64'd6);
    for (int k = 0; k < order.size(); k++) chk($sformatf("rr_order%0d", k), 64'(order[k]), 64'(k % 3));
    request = '0;
    step();

    // Held request yields exactly one access.
    md[2] = 2; lc[2] = 16'd7; wd[2] = 16'h5A5A; request[2] = 1; cnt = 0;
    for (int c = 0; c < 10; c++) begin step(); if (response[2]) cnt++; end
    chk("hold_one_response", 64'(cnt), 64'd1);
    request = '0; step();
    md[2] = 0; request[2] = 1; step(); request = '0; step();

    // Reset during a write grant drops the write.
    md[0] = 1; lc[0] = 16'd9; wd[0] = 16'h1111; request[0] = 1; step(); request = '0; step();
    wd[0] = 16'hAAAA; request[0] = 1; rst_n = 0; step();
    chk("rst_response", 64'(response), 64'd0);
    chk("rst_read_bus", 64'(read_bus), 64'd0);
    rst_n = 1;
    step(); step();
    chk("rst_unarmed", 64'(response), 64'd0);
    request = '0; step();
    md[0] = 0; md[2] = 0; lc[2] = 16'd9; request = 3'b101; step();
    chk("rst_priority", 64'(response), 64'b001);
    chk("rst_no_write", 64'(read_bus[15:0]), 64'h1111);
    request[0] = 0; step(); request = '0; step();

    // Random traffic against the model.
    for (int i = 0; i < NP; i++) served[i] = 0;
    for (int c = 0; c < 400; c++) begin
      step();
      for (int i = 0; i < NP; i++) begin
        if (response[i]) served[i] = 1;
        if (request[i]) begin
          if (served[i] && $urandom_range(3) != 0) begin request[i] = 0; served[i] = 0; end
        end else if ($urandom_range(1) == 1) begin
          r = int'($urandom_range(9));
          md[i] = (r == 0) ? 2'd3 : 2'(r % 3);
          lc[i] = ($urandom_range(7) == 0) ? 16'(1020 + $urandom_range(10)) : 16'($urandom_range(15));
          wd[i] = 16'($urandom);
          request[i] = 1;
        end
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
